instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: halfword-address width.
REQ-002 SHALL have parameter WORD_W, default 16: halfword width; instruction width is 2*WORD_W.
REQ-003 SHALL have parameter QDEPTH, default 4: halfword queue depth; power of 2, >=2.
REQ-004 SHALL have parameter RESET_PC, default 32: fetch address after reset.
REQ-005 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port imem_req, output, 1: fetch request.
REQ-008 SHALL have port imem_addr, output, ADDR_W: halfword address of the request.
REQ-009 SHALL have port imem_ready, input, 1: memory accepts the request this cycle.
REQ-010 SHALL have port imem_rdata, input, WORD_W: data, valid the cycle after acceptance.
REQ-011 SHALL have port redirect_valid, input, 1: branch/jump redirect.
REQ-012 SHALL have port redirect_pc, input, ADDR_W: redirect target.
REQ-013 SHALL have port instr_valid, output, 1: instr holds a complete instruction.
REQ-014 SHALL have port instr_ready, input, 1: decode consumes instr.
REQ-015 SHALL have port instr, output, 2*WORD_W: {first halfword, second halfword, or zero if short}.
REQ-016 SHALL have port instr_pc, output, ADDR_W: address of the first halfword.
REQ-017 SHALL have port instr_long, output, 1: instruction is two halfwords.

Function
REQ-018 Acceptance SHALL be imem_req & imem_ready; fetch_pc SHALL then increment by 1, mod 2^ADDR_W.
REQ-019 While imem_req=1 and imem_ready=0, imem_addr SHALL hold stable.
REQ-020 imem_req SHALL assert only when count + inflight < QDEPTH; inflight is 0 or 1.
REQ-021 Returned data SHALL be written to the queue tail at the end of the return cycle, unless squashed.
REQ-022 A head halfword with bit WORD_W-1 set SHALL mark a long instruction.
REQ-023 instr_valid SHALL be 1 when count>=1 for a short head, or count>=2 for a long head.
REQ-024 instr_valid SHALL be combinational from registered queue state only.
REQ-025 On instr_valid & instr_ready, the queue SHALL pop 1 (short) or 2 (long) entries.
REQ-026 On the same handshake, instr_pc SHALL advance by 1 or 2, mod 2^ADDR_W.
REQ-027 Push and pop in the same cycle SHALL both take effect; count SHALL never exceed QDEPTH.
REQ-028 Queue pointers SHALL wrap mod QDEPTH.
REQ-029 instr, instr_pc and instr_long SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-030 On redirect_valid, a handshake in that cycle SHALL count as delivered.
REQ-031 Also on redirect_valid: flush the queue, squash any in-flight return, and set fetch_pc and instr_pc to redirect_pc.
REQ-032 The cycle after a redirect, instr_valid SHALL be 0 and imem_addr SHALL equal redirect_pc.
REQ-033 A redirect while imem_req=1 and imem_ready=0 SHALL replace the pending address.
REQ-034 Redirect SHALL take priority over every other update in its cycle.
REQ-035 Latency with imem_ready=1: request at T0, data at T1, instr_valid at T2 for a short instruction; redirect-to-valid SHALL be 3 cycles.

Reset
REQ-036 While reset=1: imem_req=0, instr_valid=0, queue empty, no inflight, fetch_pc=instr_pc=RESET_PC, instr=0, instr_long=0.
REQ-037 In the first cycle with reset=0, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-038 Reset mid-operation SHALL discard queued and in-flight data; a return in the reset cycle SHALL be ignored.

Structure
REQ-039 Shared package fetch_pkg SHALL hold the parameter defaults, LONG_BIT = WORD_W-1, and function is_long(halfword).
REQ-040 The queue SHALL be a sub-module hw_fifo: parametrised, one push and a pop of 0/1/2 per cycle, with count and first two entries visible.

Verification
REQ-041 Reset release, imem_ready=1, memory returns 0x0001 at every address -> imem_addr 32,33,34...; instr_valid at T2; instr=0x00010000, instr_pc=32, then 33.
REQ-042 Halfwords 0x8001,0x1234 at 32,33 -> one instr=0x80011234, instr_long=1, instr_pc=32; next instr_pc=34.
REQ-043 instr_ready=0, QDEPTH=4 -> exactly 4 accepts, then imem_req=0; one short pop -> imem_req reasserts the next cycle.
REQ-044 redirect_pc=0x100 with an in-flight return -> stale data is not enqueued; next instr_pc=0x100.
REQ-045 Long head with count=1 and imem_ready toggling -> instr_valid stays 0 until the second halfword arrives, and addr stays stable while not ready.
REQ-046 fetch_pc=0xFFFFFFFF -> next imem_addr=0x00000000; instr_pc wraps identically.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults and halfword decode helper for the fetch unit
package fetch_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int WORD_W_DEF   = 16;
    localparam int QDEPTH_DEF   = 4;
    localparam int RESET_PC_DEF = 32;

    // Top bit of the first halfword marks a two-halfword instruction
    localparam int LONG_BIT = WORD_W_DEF - 1;

    function automatic logic is_long(input logic [WORD_W_DEF-1:0] halfword);
        return halfword[LONG_BIT];
    endfunction

endpackage

// File: rtl/hw_fifo.sv
// rtl/hw_fifo.sv - halfword queue with one push and a 0/1/2 pop per cycle
module hw_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = WORD_W_DEF,
    parameter int DEPTH = QDEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic [1:0]                 pop_n,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head0,
    output logic [WIDTH-1:0]           head1
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr + PW'(pop_n);
            cnt    <= cnt + CW'(push) - CW'(pop_n);
        end
    end

    // Storage carries no reset; a cleared queue simply ignores stale entries
    always_ff @(posedge clk) begin
        if (push && !(reset || flush)) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign count = cnt;
    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - halfword fetch engine assembling short/long instructions
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          WORD_W   = WORD_W_DEF,
    parameter int          QDEPTH   = QDEPTH_DEF,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic                  imem_ready,
    input  logic [WORD_W-1:0]     imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [2*WORD_W-1:0]   instr,
    output logic [ADDR_W-1:0]     instr_pc,
    output logic                  instr_long
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] head_pc;
    logic              inflight;
    logic [CW-1:0]     q_count;
    logic [WORD_W-1:0] head0;
    logic [WORD_W-1:0] head1;
    logic              head_long;
    logic              q_nonempty;
    logic              can_issue;
    logic              accept;
    logic              deliver;
    logic              push;
    logic [1:0]        pop_n;

    hw_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (imem_rdata),
        .pop_n     (pop_n),
        .count     (q_count),
        .head0     (head0),
        .head1     (head1)
    );

    assign head_long  = is_long(head0);
    assign q_nonempty = (q_count != '0);

    // Reserve a queue slot for every outstanding request so returns never overflow
    assign can_issue = (q_count + CW'(inflight)) < CW'(QDEPTH);
    assign imem_req  = !reset && can_issue;
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;

    // A return is only kept if its request survived: redirect squashes it, reset clears the queue
    assign push = inflight && !redirect_valid;

    assign instr_valid = !reset && (head_long ? (q_count >= CW'(2)) : q_nonempty);
    assign deliver     = instr_valid && instr_ready;
    assign pop_n       = deliver ? (head_long ? 2'd2 : 2'd1) : 2'd0;

    assign instr      = (!reset && q_nonempty) ? {head0, (head_long ? head1 : {WORD_W{1'b0}})}
                                               : {2*WORD_W{1'b0}};
    assign instr_long = !reset && q_nonempty && head_long;
    assign instr_pc   = head_pc;

    // Request address and outstanding-return tracking; redirect overrides any acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= ADDR_W'(RESET_PC);
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
            inflight <= accept;
        end
    end

    // Address of the instruction at the queue head, advanced by its size on delivery
    always_ff @(posedge clk) begin
        if (reset) begin
            head_pc <= ADDR_W'(RESET_PC);
        end else if (redirect_valid) begin
            head_pc <= redirect_pc;
        end else if (deliver) begin
            head_pc <= head_pc + (head_long ? ADDR_W'(2) : ADDR_W'(1));
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_long;

    int n_total = 0;
    int n_bad   = 0;
    int acc_count = 0;
    int mem_mode  = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_long     (instr_long)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [31:0] a);
        case (mem_mode)
            1:       return (a == 32'd32) ? 16'h8001 : ((a == 32'd33) ? 16'h1234 : 16'h0001);
            2:       return {1'b0, a[14:0]};
            default: return 16'h0001;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: sample the request handshake, then present the memory response after the edge
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = imem_req & imem_ready;
        a   = imem_addr;
        if (acc) acc_count++;
        @(posedge clk);
        #1;
        imem_rdata = acc ? mem_fn(a) : 16'hDEAD;
    endtask

    task automatic do_reset(input int mode, input logic rdy);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        imem_ready     = rdy;
        mem_mode       = mode;
        tick();
        tick();
        reset     = 1'b0;
        acc_count = 0;
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 16'h0; redirect_valid = 1'b0;
        redirect_pc = '0; instr_ready = 1'b0; mem_mode = 0;

        // Reset state and first fetch sequence with all-0x0001 memory
        tick();
        @(negedge clk);
        check("rst_req",   imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_long",  instr_long, 0);
        check("rst_pc",    instr_pc, 32);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t0_req",   imem_req, 1);
        check("t0_addr",  imem_addr, 32);
        check("t0_valid", instr_valid, 0);
        tick();
        @(negedge clk);
        check("t1_addr",  imem_addr, 33);
        check("t1_valid", instr_valid, 0);
        tick();
        instr_ready = 1'b1;
        @(negedge clk);
        check("t2_valid", instr_valid, 1);
        check("t2_instr", instr, 32'h00010000);
        check("t2_pc",    instr_pc, 32);
        check("t2_addr",  imem_addr, 34);
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        check("t3_pc",    instr_pc, 33);
        check("t3_valid", instr_valid, 1);

        // Queue full back-pressure: four accepts, then one short pop reopens a slot
        do_reset(0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tick();
        end
        instr_ready = 1'b1;
        @(negedge clk);
        check("full_accepts", acc_count, 4);
        check("full_req",     imem_req, 0);
        check("full_valid",   instr_valid, 1);
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        check("reopen_req",  imem_req, 1);
        check("reopen_addr", imem_addr, 36);
        check("reopen_pc",   instr_pc, 33);

        // Long instruction assembled from 0x8001, 0x1234
        do_reset(1, 1'b1);
        @(negedge clk); tick();
        @(negedge clk); tick();
        @(negedge clk);
        check("long_half_valid", instr_valid, 0);
        tick();
        instr_ready = 1'b1;
        @(negedge clk);
        check("long_valid", instr_valid, 1);
        check("long_instr", instr, 32'h80011234);
        check("long_flag",  instr_long, 1);
        check("long_pc",    instr_pc, 32);
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        check("after_long_pc",    instr_pc, 34);
        check("after_long_instr", instr, 32'h00010000);
        check("after_long_flag",  instr_long, 0);

        // Long head with only one halfword while memory stalls
        do_reset(1, 1'b1);
        @(negedge clk);
        check("stall_t0_addr", imem_addr, 32);
        tick();
        imem_ready = 1'b0;
        @(negedge clk);
        check("stall_t1_addr", imem_addr, 33);
        tick();
        @(negedge clk);
        check("stall_t2_valid", instr_valid, 0);
        check("stall_t2_addr",  imem_addr, 33);
        check("stall_t2_req",   imem_req, 1);
        tick();
        imem_ready = 1'b1;
        @(negedge clk);
        check("stall_t3_valid", instr_valid, 0);
        check("stall_t3_addr",  imem_addr, 33);
        tick();
        @(negedge clk);
        check("stall_t4_valid", instr_valid, 0);
        check("stall_t4_addr",  imem_addr, 34);
        tick();
        @(negedge clk);
        check("stall_t5_valid", instr_valid, 1);
        check("stall_t5_instr", instr, 32'h80011234);

        // Redirect squashes the in-flight return
        do_reset(2, 1'b1);
        @(negedge clk); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk); tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_valid", instr_valid, 0);
        check("redir_addr",  imem_addr, 32'h100);
        check("redir_req",   imem_req, 1);
        tick();
        @(negedge clk);
        check("redir_t3_valid", instr_valid, 0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        @(negedge clk);
        check("redir_t4_valid", instr_valid, 1);
        check("redir_t4_pc",    instr_pc, 32'h100);
        check("redir_t4_instr", instr, 32'h01000000);

        // Address wrap at the top of the address space
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_addr0",  imem_addr, 32'hFFFF_FFFF);
        check("wrap_valid0", instr_valid, 0);
        tick();
        @(negedge clk);
        check("wrap_addr1", imem_addr, 32'h0);
        tick();
        instr_ready = 1'b1;
        @(negedge clk);
        check("wrap_valid", instr_valid, 1);
        check("wrap_pc",    instr_pc, 32'hFFFF_FFFF);
        check("wrap_instr", instr, 32'h7FFF0000);
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        check("wrap_pc_next",    instr_pc, 32'h0);
        check("wrap_instr_next", instr, 32'h0);
        check("wrap_valid_next", instr_valid, 1);

        // Redirect while a request is stalled replaces the pending address
        do_reset(2, 1'b0);
        @(negedge clk);
        check("pend_t0_addr", imem_addr, 32);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        check("pend_t1_addr", imem_addr, 32);
        tick();
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        @(negedge clk);
        check("pend_t2_addr", imem_addr, 32'h200);
        check("pend_t2_req",  imem_req, 1);
        tick();
        @(negedge clk);
        check("pend_t3_addr", imem_addr, 32'h201);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
